// File: rtl/act_result_collector_if.sv
// Bus bundle for act_result_collector: activation beat input on one side,
// host read port and FIFO status on the other.
//
// Handshake: a beat transfers on a rising edge where act_valid && act_ready.
// act_valid/act_data/act_last must stay stable until that edge; act_ready
// may drop while a packed word is waiting for FIFO space. rd_en is a plain
// strobe (no ready): each cycle it is high pops one word, and read_valid
// pulses one cycle later alongside read_data.
interface act_result_collector_if #(
  parameter int Q_SIZE    = 16,
  parameter int MM_SIZE   = 32,
  parameter int OUT_DEPTH = 8
);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic              act_valid;
  logic [Q_SIZE-1:0] act_data;
  logic              act_last;
  logic              act_ready;
  logic              rd_en;
  logic [MM_SIZE-1:0] read_data;
  logic              read_valid;
  logic [CW-1:0]     word_count;
  logic              empty;
  logic              full;
  logic              underflow;
  logic              layer_done;

  // Upstream activation stage plus host
  modport master (
    output act_valid, act_data, act_last, rd_en,
    input  act_ready, read_data, read_valid, word_count,
           empty, full, underflow, layer_done
  );

  // The collector itself
  modport slave (
    input  act_valid, act_data, act_last, rd_en,
    output act_ready, read_data, read_valid, word_count,
           empty, full, underflow, layer_done
  );
endinterface

// File: rtl/act_result_collector.sv
// Packs a serial stream of activated Q-format values into host-width words,
// buffers them in a small circular FIFO and serves them to a host read port.
// A partial word at layer end is zero-padded and committed, and layer_done
// pulses once the word carrying act_last has entered the FIFO.
module act_result_collector #(
  parameter int Q_SIZE    = 16,
  parameter int MM_SIZE   = 32,
  parameter int OUT_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  act_result_collector_if.slave  bus,
  output logic                   pack_state
);
  localparam int PACK = MM_SIZE / Q_SIZE;
  localparam int LW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW   = $clog2(OUT_DEPTH);
  localparam int CW   = $clog2(OUT_DEPTH + 1);

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t             state;
  logic [LW-1:0]      lane_idx;
  logic [MM_SIZE-1:0] pack_reg;
  logic               last_flag;
  logic               layer_done_r;

  logic [MM_SIZE-1:0] mem [OUT_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [MM_SIZE-1:0] read_data_r;
  logic               read_valid_r;
  logic               underflow_r;

  logic word_pending;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign word_pending = (state == PENDING);
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CW'(OUT_DEPTH));
  // A full FIFO still takes the pending word when the host pops on the same
  // edge, so the packer never stalls longer than the host does.
  assign push         = word_pending && (!fifo_full || bus.rd_en);
  assign pop          = bus.rd_en && !fifo_empty;

  assign bus.act_ready  = !word_pending;
  assign bus.read_data  = read_data_r;
  assign bus.read_valid = read_valid_r;
  assign bus.word_count = count;
  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.underflow  = underflow_r;
  assign bus.layer_done = layer_done_r;
  assign pack_state     = state;

  // Packer FSM: fill lanes LSB-first, then hold the word until the FIFO takes it
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= FILL;
      lane_idx     <= '0;
      pack_reg     <= '0;
      last_flag    <= 1'b0;
      layer_done_r <= 1'b0;
    end else begin
      layer_done_r <= 1'b0;
      case (state)
        FILL: begin
          if (bus.act_valid) begin
            for (int i = 0; i < PACK; i++) begin
              if (lane_idx == LW'(i)) pack_reg[i*Q_SIZE +: Q_SIZE] <= bus.act_data;
            end
            if (bus.act_last || lane_idx == LW'(PACK - 1)) begin
              state     <= PENDING;
              lane_idx  <= '0;
              last_flag <= bus.act_last;
            end else begin
              lane_idx <= lane_idx + 1'b1;
            end
          end
        end
        PENDING: begin
          if (push) begin
            // Zeroing here is what makes unwritten lanes of a short word read as 0
            pack_reg     <= '0;
            state        <= FILL;
            layer_done_r <= last_flag;
            last_flag    <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pack_reg;
  end

  // FIFO pointers, occupancy and the registered host read port
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      read_data_r  <= '0;
      read_valid_r <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      read_valid_r <= bus.rd_en;
      if (bus.rd_en) begin
        if (fifo_empty) begin
          // A word pushed on this same edge is not visible to this pop
          read_data_r <= '0;
          underflow_r <= 1'b1;
        end else begin
          read_data_r <= mem[rd_ptr];
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_act_result_collector.sv
// Directed bench for act_result_collector with Q_SIZE=16, MM_SIZE=32,
// OUT_DEPTH=4. Inputs change 1ns after a rising edge; outputs are sampled
// at the same point, i.e. after the edge has settled.
module tb_act_result_collector;
  localparam int Q_SIZE    = 16;
  localparam int MM_SIZE   = 32;
  localparam int OUT_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic pack_state;

  int checks   = 0;
  int failures = 0;

  act_result_collector_if #(.Q_SIZE(Q_SIZE), .MM_SIZE(MM_SIZE), .OUT_DEPTH(OUT_DEPTH)) bus ();

  act_result_collector #(.Q_SIZE(Q_SIZE), .MM_SIZE(MM_SIZE), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .pack_state (pack_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for act_ready, then presents one beat for exactly one edge
  task automatic send_beat(input logic [15:0] d, input logic l);
    int n = 0;
    while (bus.act_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("beat_ready", {31'd0, bus.act_ready}, 32'd1);
    bus.act_valid = 1'b1;
    bus.act_data  = d;
    bus.act_last  = l;
    step();
    bus.act_valid = 1'b0;
    bus.act_last  = 1'b0;
    bus.act_data  = '0;
  endtask

  // One-cycle rd_en, then checks the registered result
  task automatic do_read(input string tag, input logic [31:0] exp);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check({tag, "_valid"}, {31'd0, bus.read_valid}, 32'd1);
    check(tag, bus.read_data, exp);
  endtask

  initial begin
    logic [15:0] lo;
    logic [15:0] hi;

    reset         = 1'b1;
    clear         = 1'b0;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.act_last  = 1'b0;
    bus.rd_en     = 1'b0;
    step();
    step();

    // Reset state
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_ready", {31'd0, bus.act_ready}, 32'd1);
    check("rst_count", {29'd0, bus.word_count}, 32'd0);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_underflow", {31'd0, bus.underflow}, 32'd0);
    check("rst_read_valid", {31'd0, bus.read_valid}, 32'd0);
    check("rst_read_data", bus.read_data, 32'd0);
    check("rst_layer_done", {31'd0, bus.layer_done}, 32'd0);
    check("rst_state", {31'd0, pack_state}, 32'd0);
    reset = 1'b0;

    // Two-beat layer: one word, one bubble, one layer_done
    send_beat(16'h1111, 1'b0);
    check("t1_ready_lane1", {31'd0, bus.act_ready}, 32'd1);
    send_beat(16'h2222, 1'b1);
    check("t1_bubble", {31'd0, bus.act_ready}, 32'd0);
    check("t1_state_pending", {31'd0, pack_state}, 32'd1);
    check("t1_done_early", {31'd0, bus.layer_done}, 32'd0);
    step();
    check("t1_ready_back", {31'd0, bus.act_ready}, 32'd1);
    check("t1_count", {29'd0, bus.word_count}, 32'd1);
    check("t1_layer_done", {31'd0, bus.layer_done}, 32'd1);
    step();
    check("t1_done_pulse", {31'd0, bus.layer_done}, 32'd0);
    do_read("t1_word", 32'h2222_1111);
    step();
    check("t1_valid_pulse", {31'd0, bus.read_valid}, 32'd0);
    check("t1_data_hold", bus.read_data, 32'h2222_1111);
    check("t1_empty", {31'd0, bus.empty}, 32'd1);

    // Odd-length layer: trailing partial word is zero-padded
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b0);
    send_beat(16'hCCCC, 1'b1);
    step();
    check("t2_layer_done", {31'd0, bus.layer_done}, 32'd1);
    check("t2_count", {29'd0, bus.word_count}, 32'd2);
    do_read("t2_word0", 32'hBBBB_AAAA);
    do_read("t2_word1", 32'h0000_CCCC);

    // Overfill: 10 values, 4 words stored, 5th pending behind a full FIFO
    for (int i = 0; i < 10; i++) begin
      send_beat(16'h0100 + 16'(i), (i == 9) ? 1'b1 : 1'b0);
    end
    step();
    step();
    check("t3_count_cap", {29'd0, bus.word_count}, 32'd4);
    check("t3_full", {31'd0, bus.full}, 32'd1);
    check("t3_stalled", {31'd0, bus.act_ready}, 32'd0);
    check("t3_no_done", {31'd0, bus.layer_done}, 32'd0);
    do_read("t3_word0", 32'h0101_0100);
    check("t3_count_same", {29'd0, bus.word_count}, 32'd4);
    check("t3_full_same", {31'd0, bus.full}, 32'd1);
    check("t3_ready_after", {31'd0, bus.act_ready}, 32'd1);
    check("t3_layer_done", {31'd0, bus.layer_done}, 32'd1);
    do_read("t3_word1", 32'h0103_0102);
    do_read("t3_word2", 32'h0105_0104);
    do_read("t3_word3", 32'h0107_0106);
    do_read("t3_word4", 32'h0109_0108);
    check("t3_drained", {31'd0, bus.empty}, 32'd1);

    // Underflow, including a pop-while-empty on the same edge as a push
    do_read("t4_uf_data", 32'h0000_0000);
    check("t4_underflow", {31'd0, bus.underflow}, 32'd1);
    send_beat(16'hDEAD, 1'b0);
    send_beat(16'hBEEF, 1'b1);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("t4_same_valid", {31'd0, bus.read_valid}, 32'd1);
    check("t4_same_data", bus.read_data, 32'h0000_0000);
    check("t4_same_count", {29'd0, bus.word_count}, 32'd1);
    check("t4_same_done", {31'd0, bus.layer_done}, 32'd1);
    do_read("t4_after", 32'hBEEF_DEAD);
    check("t4_sticky", {31'd0, bus.underflow}, 32'd1);

    // Soft clear flushes stored words, the partial lane and underflow
    send_beat(16'h7777, 1'b0);
    send_beat(16'h8888, 1'b0);
    step();
    send_beat(16'h9999, 1'b0);
    check("tc_count_before", {29'd0, bus.word_count}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("tc_count", {29'd0, bus.word_count}, 32'd0);
    check("tc_empty", {31'd0, bus.empty}, 32'd1);
    check("tc_underflow", {31'd0, bus.underflow}, 32'd0);
    send_beat(16'h0C0C, 1'b1);
    step();
    do_read("tc_word", 32'h0000_0C0C);

    // Pointer wrap: fill, drain, refill, drain
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        lo = ((pass == 0) ? 16'h3000 : 16'h4000) + 16'(2 * i);
        send_beat(lo, 1'b0);
        send_beat(lo + 16'd1, 1'b0);
      end
      step();
      check("t5_full", {31'd0, bus.full}, 32'd1);
      for (int i = 0; i < 4; i++) begin
        lo = ((pass == 0) ? 16'h3000 : 16'h4000) + 16'(2 * i);
        hi = lo + 16'd1;
        do_read("t5_word", {hi, lo});
      end
      check("t5_empty", {31'd0, bus.empty}, 32'd1);
    end

    // Hard reset discards a half-filled word
    send_beat(16'h5555, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_empty", {31'd0, bus.empty}, 32'd1);
    check("t6_count", {29'd0, bus.word_count}, 32'd0);
    check("t6_ready", {31'd0, bus.act_ready}, 32'd1);
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b1);
    step();
    do_read("t6_word", 32'h0002_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
